// File: rtl/spi_block_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | spi_block_ctrl_pkg: shared widths and sequencer state encoding      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package spi_block_ctrl_pkg;

  localparam int SPI_BYTE_W  = 8;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_GAP       = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_block_shifter.sv
// +--------------------------------------------------------------------+
// | spi_block_shifter: parallel-load tx byte shifter, serial-in rx     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_block_shifter
  import spi_block_ctrl_pkg::*;
#(
  parameter int NUM_BYTES = AES_BLOCK_W / SPI_BYTE_W
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              load_i,
  input  logic [SPI_BYTE_W*NUM_BYTES-1:0]   block_i,
  input  logic                              shift_tx_i,
  input  logic                              shift_rx_i,
  input  logic [SPI_BYTE_W-1:0]             rx_byte_i,
  output logic [SPI_BYTE_W-1:0]             tx_byte_o,
  output logic [SPI_BYTE_W*NUM_BYTES-1:0]   rx_block_o
);

  localparam int BW = SPI_BYTE_W * NUM_BYTES;

  logic [BW-1:0]            tx_q, tx_d;
  // Only N-1 earlier bytes need storing; the newest byte comes straight from rx_byte_i.
  logic [BW-SPI_BYTE_W-1:0] rx_q, rx_d;

  assign tx_byte_o  = tx_q[BW-1 -: SPI_BYTE_W];
  assign rx_block_o = {rx_q, rx_byte_i};

  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load_i) begin
      tx_d = block_i;
      rx_d = '0;
    end else begin
      if (shift_tx_i) tx_d = {tx_q[BW-SPI_BYTE_W-1:0], {SPI_BYTE_W{1'b0}}};
      if (shift_rx_i) rx_d = rx_block_o[BW-SPI_BYTE_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_block_ctrl.sv
// +--------------------------------------------------------------------+
// | spi_block_ctrl: sends one block as back-to-back byte transactions  |
// | and reassembles the reply. Optional watchdog: SPI_BLOCK_TIMEOUT_EN |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_block_ctrl
  import spi_block_ctrl_pkg::*;
#(
  parameter int NUM_BYTES  = AES_BLOCK_W / SPI_BYTE_W,
  parameter int GAP_CYCLES = 2
`ifdef SPI_BLOCK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [SPI_BYTE_W*NUM_BYTES-1:0]   block_in,
  output logic                              busy,
  output logic                              done,
  output logic [SPI_BYTE_W*NUM_BYTES-1:0]   block_out,
  output logic                              m_start,
  output logic [SPI_BYTE_W-1:0]             m_data_in,
  input  logic                              m_busy,
  input  logic                              m_done,
  input  logic [SPI_BYTE_W-1:0]             m_data_out
`ifdef SPI_BLOCK_TIMEOUT_EN
  , output logic                            timeout
`endif
);

  localparam int BW = SPI_BYTE_W * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  m_start_q, m_start_d;
  logic [SPI_BYTE_W-1:0] m_data_in_q, m_data_in_d;
  logic [BW-1:0]         block_out_q, block_out_d;

  logic                  tx_load, tx_shift, rx_shift;
  logic [SPI_BYTE_W-1:0] tx_byte;
  logic [BW-1:0]         rx_block;

`ifdef SPI_BLOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]         wd_q, wd_d;
  logic                  timeout_q, timeout_d;
  assign timeout = timeout_q;
`endif

  spi_block_shifter #(
    .NUM_BYTES (NUM_BYTES)
  ) u_shifter (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (tx_load),
    .block_i    (block_in),
    .shift_tx_i (tx_shift),
    .shift_rx_i (rx_shift),
    .rx_byte_i  (m_data_out),
    .tx_byte_o  (tx_byte),
    .rx_block_o (rx_block)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign block_out = block_out_q;
  assign m_start   = m_start_q;
  assign m_data_in = m_data_in_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    m_start_d   = 1'b0;
    m_data_in_d = m_data_in_q;
    block_out_d = block_out_q;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
`ifdef SPI_BLOCK_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_load    = 1'b1;
          byte_cnt_d = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!m_busy) begin
          m_start_d   = 1'b1;
          m_data_in_d = tx_byte;
          tx_shift    = 1'b1;
          state_d     = ST_WAIT_DONE;
`ifdef SPI_BLOCK_TIMEOUT_EN
          wd_d        = '0;
`endif
        end
      end
      ST_WAIT_DONE: begin
        if (m_done) begin
          rx_shift = 1'b1;
          if (byte_cnt_q == CW'(NUM_BYTES - 1)) begin
            // Load the result now so block_out is already valid on the done cycle.
            block_out_d = rx_block;
            state_d     = ST_FINISH;
          end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
            gap_cnt_d  = '0;
            state_d    = ST_GAP;
          end
        end
`ifdef SPI_BLOCK_TIMEOUT_EN
        else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + TW'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = ST_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      m_start_q   <= 1'b0;
      m_data_in_q <= '0;
      block_out_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      m_start_q   <= m_start_d;
      m_data_in_q <= m_data_in_d;
      block_out_q <= block_out_d;
    end
  end

`ifdef SPI_BLOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_block_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_spi_block_ctrl: directed bench with a transaction-level model   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_block_ctrl;

  localparam int N   = 16;
  localparam int GAP = 2;
  localparam int BW  = 8 * N;

  localparam logic [BW-1:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [BW-1:0] B2 = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
  localparam logic [BW-1:0] B3 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [BW-1:0] B4 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] block_in = '0;
  logic          busy, done, m_start;
  logic [BW-1:0] block_out;
  logic [7:0]    m_data_in;
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [7:0]    m_data_out = '0;
`ifdef SPI_BLOCK_TIMEOUT_EN
  logic          timeout;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_block_ctrl #(
    .NUM_BYTES  (N),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .block_in   (block_in),
    .busy       (busy),
    .done       (done),
    .block_out  (block_out),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_busy     (m_busy),
    .m_done     (m_done),
    .m_data_out (m_data_out)
`ifdef SPI_BLOCK_TIMEOUT_EN
    , .timeout  (timeout)
`endif
  );

  function automatic void chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Slave: answers each m_start after a varying latency, echoing or returning A5.
  int         slave_mode = 0;
  bit         slave_en = 1'b1;
  int         lat_ix = 0;
  logic [7:0] sl_b;
  int         sl_lat;

  initial forever begin
    @(negedge clk);
    if (slave_en && reset_n && m_start) begin
      sl_b   = m_data_in;
      sl_lat = 1 + (lat_ix % 4);
      lat_ix++;
      @(posedge clk); #1 m_busy = 1'b1;
      repeat (sl_lat) @(posedge clk);
      #1;
      m_busy     = 1'b0;
      m_done     = 1'b1;
      m_data_out = (slave_mode == 0) ? sl_b : 8'hA5;
      @(posedge clk); #1 m_done = 1'b0;
    end
  end

  // Transaction-level model: block accepted when idle, bytes go out MSB first,
  // replies concatenate in arrival order, done one cycle after the last reply.
  bit            chk_en = 1'b1;
  bit            act = 1'b0;
  int            sent = 0, rcvd = 0, since = 100;
  logic [BW-1:0] blk = '0, rx = '0;
  logic          exp_busy = 1'b0, exp_done = 1'b0;
  logic [BW-1:0] exp_bo = '0;
  logic [7:0]    exp_mdi = '0;
  int            n_pulse = 0, n_done = 0;
  logic [7:0]    mdi_log[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      if (chk_en) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_block_out", block_out, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_data_in", m_data_in, 0);
      end
      act = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_bo = '0; exp_mdi = '0;
      sent = 0; rcvd = 0;
    end else if (chk_en) begin
      since++;
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("block_out", block_out, exp_bo);
      if (done) n_done++;
      if (m_start) begin
        n_pulse++;
        mdi_log.push_back(m_data_in);
        chk("m_start_expected", act && sent < N, 1);
        if (act && sent < N) begin
          chk("m_data_in_byte", m_data_in, blk[BW-1-8*sent -: 8]);
          exp_mdi = blk[BW-1-8*sent -: 8];
        end
        chk("gap_after_m_done", (since - 1) >= GAP, 1);
        sent++;
      end else begin
        chk("m_data_in_hold", m_data_in, exp_mdi);
      end
      if (act && exp_done) begin
        act = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
      end else if (!act) begin
        exp_done = 1'b0;
        if (start) begin
          act = 1'b1; exp_busy = 1'b1; blk = block_in;
          sent = 0; rcvd = 0; since = 100;
        end
      end else begin
        exp_done = 1'b0;
        if (m_done && rcvd < sent) begin
          rx = {rx[BW-9:0], m_data_out};
          rcvd++;
          since = 0;
          if (rcvd == N) begin
            exp_done = 1'b1;
            exp_bo   = rx;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [BW-1:0] b);
    @(posedge clk); #1;
    block_in = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Returns at the falling edge of the done cycle (or when the budget runs out).
  task automatic wait_done(input string nm, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, seen, 1);
  endtask

  task automatic wait_pulses(input string nm, input int base, input int cnt);
    bit hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (m_start && (n_pulse - base) >= cnt) begin
        hit = 1'b1;
        break;
      end
    end
    chk(nm, hit, 1);
  endtask

  int p0, d0;

  initial begin
    tick(3);
    chk("reset_block_out_lit", block_out, 0);
    reset_n = 1'b1;
    tick(2);

    // T1: loopback, bytes must leave MSB first and return unchanged
    slave_mode = 0;
    mdi_log.delete();
    p0 = n_pulse; d0 = n_done;
    launch(B1);
    wait_done("t1_done_seen", 2000);
    chk("t1_block_out", block_out, B1);
    chk("t1_log_size", mdi_log.size(), 16);
    chk("t1_first_byte", mdi_log[0], 8'h00);
    chk("t1_second_byte", mdi_log[1], 8'h11);
    chk("t1_last_byte", mdi_log[15], 8'hFF);
    tick(3);
    chk("t1_pulses", n_pulse - p0, 16);
    chk("t1_dones", n_done - d0, 1);

    // T2: constant slave reply
    slave_mode = 1;
    p0 = n_pulse;
    launch(B2);
    wait_done("t2_done_seen", 2000);
    chk("t2_block_out", block_out, {16{8'hA5}});
    tick(3);
    chk("t2_pulses", n_pulse - p0, 16);

    // T3: start held for 3 cycles, then re-pulsed during byte 5
    slave_mode = 0;
    p0 = n_pulse; d0 = n_done;
    @(posedge clk); #1;
    block_in = B3;
    start    = 1'b1;
    tick(3);
    start    = 1'b0;
    wait_pulses("t3_reach_byte5", p0, 5);
    block_in = B4;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
    wait_done("t3_done_seen", 2000);
    chk("t3_block_out", block_out, B3);
    tick(40);
    chk("t3_pulses", n_pulse - p0, 16);
    chk("t3_dones", n_done - d0, 1);
    chk("t3_idle_after", busy, 0);

    // T4: asynchronous reset during byte 7
    p0 = n_pulse;
    launch(B2);
    wait_pulses("t4_reach_byte7", p0, 7);
    reset_n = 1'b0;
    #1;
    chk("t4_busy_drop", busy, 0);
    chk("t4_m_start_drop", m_start, 0);
    chk("t4_done_low", done, 0);
    chk("t4_block_out_zero", block_out, 0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    chk("t4_block_out_after", block_out, 0);
    launch(B3);
    wait_done("t4_done_seen", 2000);
    chk("t4_block_out_new", block_out, B3);

    // T6: start on the done cycle is ignored, start one cycle later is taken
    tick(2);
    launch(B1);
    wait_done("t6a_done_seen", 2000);
    #1;
    block_in = B2;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    tick(3);
    chk("t6_start_on_done_ignored", busy, 0);
    chk("t6_block_out_held", block_out, B1);
    launch(B2);
    wait_done("t6b_done_seen", 2000);
    #1;
    block_in = B4;
    start    = 1'b1;
    tick(2);
    start    = 1'b0;
    chk("t6_start_after_done_taken", busy, 1);
    wait_done("t6c_done_seen", 2000);
    chk("t6_block_out_new", block_out, B4);

`ifdef SPI_BLOCK_TIMEOUT_EN
    // T5: unresponsive master trips the watchdog
    begin
      bit seen_done = 1'b0;
      bit seen_to = 1'b0;
      int cyc = 0;
      tick(4);
      chk_en   = 1'b0;
      slave_en = 1'b0;
      launch(B1);
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        cyc++;
        if (done) seen_done = 1'b1;
        if (timeout) begin
          seen_to = 1'b1;
          break;
        end
      end
      chk("t5_timeout_set", seen_to, 1);
      chk("t5_no_done", seen_done, 0);
      chk("t5_min_wait", cyc >= 64, 1);
      chk("t5_busy_low", busy, 0);
      chk("t5_block_out_kept", block_out, B4);
      tick(5);
      chk("t5_sticky", timeout, 1);
      reset_n = 1'b0;
      #1;
      chk("t5_reset_clears", timeout, 0);
      tick(2);
      reset_n  = 1'b1;
      slave_en = 1'b1;
      chk_en   = 1'b1;
      tick(2);
    end
`endif

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "run exceeded time budget");
  end

endmodule

`default_nettype wire
